// File: rtl/lsu_agu_split_pkg.sv
// rtl/lsu_agu_split_pkg.sv - shared size codes, FSM encodings and lane helpers for the AGU
package lsu_agu_split_pkg;

  localparam int XLEN_C = 32;
  localparam int LANES  = XLEN_C / 8;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD0 = 3'd1;
  localparam logic [2:0] RSP0 = 3'd2;
  localparam logic [2:0] CMD1 = 3'd3;
  localparam logic [2:0] RSP1 = 3'd4;
  localparam logic [2:0] WB   = 3'd5;

  // Byte-enable pattern of an access at offset 0, widened so it can be shifted across two beats
  function automatic logic [2*LANES-1:0] size_mask8(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask8 = 8'b0000_0001;
      SZ_H:    size_mask8 = 8'b0000_0011;
      SZ_W:    size_mask8 = 8'b0000_1111;
      default: size_mask8 = 8'b0000_0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    misaligned = (size == SZ_R) ||
                 ((size == SZ_H) && (off == 2'd3)) ||
                 ((size == SZ_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_agu_split_if.sv
// rtl/lsu_agu_split_if.sv - op, bus command/response and write-back channels of the AGU
interface lsu_agu_split_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16,
  parameter int ITAG_W = 2
);
  logic              i_valid;
  logic              i_ready;
  logic [XLEN-1:0]   i_rs1;
  logic [XLEN-1:0]   i_rs2;
  logic [XLEN-1:0]   i_imm;
  logic              i_load;
  logic              i_store;
  logic [1:0]        i_size;
  logic              i_usign;
  logic [ITAG_W-1:0] i_itag;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_read;
  logic [XLEN-1:0]   cmd_wdata;
  logic [XLEN/8-1:0] cmd_wmask;
  logic [ITAG_W-1:0] cmd_itag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  logic              o_valid;
  logic              o_ready;
  logic [XLEN-1:0]   o_wdat;
  logic [ITAG_W-1:0] o_itag;
  logic              o_err;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_imm, i_load, i_store, i_size, i_usign, i_itag,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, o_ready,
    output i_ready, cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_itag,
    output rsp_ready, o_valid, o_wdat, o_itag, o_err
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_imm, i_load, i_store, i_size, i_usign, i_itag,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, o_ready,
    input  i_ready, cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_itag,
    input  rsp_ready, o_valid, o_wdat, o_itag, o_err
  );
endinterface

// File: rtl/lsu_agu_ldalign.sv
// rtl/lsu_agu_ldalign.sv - combinational load data alignment and sign/zero extension
module lsu_agu_ldalign
  import lsu_agu_split_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata0,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            usign,
  output logic [XLEN-1:0] wdat
);

  logic [XLEN-1:0] shifted;

  assign shifted = XLEN'({rdata1, rdata0} >> {off, 3'b000});

  always_comb begin
    wdat = shifted;
    case (size)
      SZ_B:    wdat = {{(XLEN-8){~usign & shifted[7]}}, shifted[7:0]};
      SZ_H:    wdat = {{(XLEN-16){~usign & shifted[15]}}, shifted[15:0]};
      default: wdat = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_agu_split.sv
// rtl/lsu_agu_split.sv - load/store AGU issuing word-aligned beats, splitting misaligned accesses
module lsu_agu_split
  import lsu_agu_split_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 16,
  parameter int ITAG_W   = 2,
  parameter int SPLIT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  lsu_agu_split_if.slave   bus
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   rs2_q;
  logic [XLEN-1:0]   rdata0_q;
  logic [XLEN-1:0]   rdata1_q;
  logic [1:0]        size_q;
  logic              usign_q;
  logic              load_q;
  logic              split_q;
  logic              err_q;
  logic [ITAG_W-1:0] itag_q;

  logic [ADDR_W-1:0] acc_addr;
  logic              acc_mem;
  logic              acc_mis;
  logic              acc_can_split;
  logic [7:0]        m8;
  logic [XLEN-1:0]   ld_wdat;

  assign acc_addr      = bus.i_rs1[ADDR_W-1:0] + bus.i_imm[ADDR_W-1:0];
  assign acc_mem       = bus.i_load | bus.i_store;
  assign acc_mis       = misaligned(bus.i_size, acc_addr[1:0]);
  assign acc_can_split = (SPLIT_EN != 0) && (bus.i_size != SZ_R);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      rs2_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      size_q   <= '0;
      usign_q  <= 1'b0;
      load_q   <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      itag_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          addr_q   <= acc_addr;
          rs2_q    <= bus.i_rs2;
          size_q   <= bus.i_size;
          usign_q  <= bus.i_usign;
          load_q   <= bus.i_load;
          itag_q   <= bus.i_itag;
          rdata0_q <= '0;
          rdata1_q <= '0;
          split_q  <= acc_mis & acc_can_split;
          // Non-memory ops and unsplittable misaligned ops complete without touching the bus
          err_q    <= acc_mem & acc_mis & ~acc_can_split;
          if (!acc_mem || (acc_mis && !acc_can_split)) state <= WB;
          else                                          state <= CMD0;
        end
        CMD0: if (bus.cmd_ready) state <= RSP0;
        RSP0: if (bus.rsp_valid) begin
          rdata0_q <= bus.rsp_rdata;
          err_q    <= bus.rsp_err;
          if (bus.rsp_err)  state <= WB;
          else if (split_q) state <= CMD1;
          else              state <= WB;
        end
        CMD1: if (bus.cmd_ready) state <= RSP1;
        RSP1: if (bus.rsp_valid) begin
          rdata1_q <= bus.rsp_rdata;
          err_q    <= err_q | bus.rsp_err;
          state    <= WB;
        end
        WB:   if (bus.o_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m8 = size_mask8(size_q) << addr_q[1:0];

  assign bus.i_ready   = (state == IDLE);
  assign bus.cmd_valid = (state == CMD0) || (state == CMD1);
  assign bus.cmd_addr  = {addr_q[ADDR_W-1:2], 2'b00} + ((state == CMD1) ? ADDR_W'(4) : '0);
  assign bus.cmd_read  = load_q;
  // Rotate store data left by the byte offset so each byte lands on its lane in either beat
  assign bus.cmd_wdata = XLEN'({rs2_q, rs2_q} >> (XLEN - 8 * int'(addr_q[1:0])));
  assign bus.cmd_wmask = load_q ? '0 : ((state == CMD1) ? m8[7:4] : m8[3:0]);
  assign bus.cmd_itag  = itag_q;
  assign bus.rsp_ready = (state == RSP0) || (state == RSP1);

  lsu_agu_ldalign #(.XLEN(XLEN)) u_ldalign (
    .rdata1 (rdata1_q),
    .rdata0 (rdata0_q),
    .off    (addr_q[1:0]),
    .size   (size_q),
    .usign  (usign_q),
    .wdat   (ld_wdat)
  );

  assign bus.o_valid = (state == WB);
  assign bus.o_wdat  = (load_q && !err_q) ? ld_wdat : '0;
  assign bus.o_itag  = itag_q;
  assign bus.o_err   = err_q;

endmodule

// File: doc/lsu_agu_split.md
Name: lsu_agu_split

Overview:
- Second-generation load/store address generation unit for the EXU-to-LSU path.
- Computes the effective address rs1+imm with its own adder; it does not share the ALU datapath.
- Issues word-aligned bus commands to LSU-ctrl or the DTCM. Misaligned halfword/word accesses are split into two aligned beats.
- For split loads, the two responses are merged, shifted and sign- or zero-extended before one write-back.
- Every accepted op gets exactly one write-back carrying itag and error. Stores write back data 0.

Parameters:
- XLEN, 32, datapath width; only 32 is supported, giving 4 byte lanes.
- ADDR_W, 16, bus address width; the effective address is truncated to ADDR_W bits.
- ITAG_W, 2, instruction tag width.
- SPLIT_EN, 1, selects misaligned handling: 1 splits into two beats; 0 reports a misaligned error with no bus command.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  op request valid
- i_ready  out  1  op accepted when i_valid and i_ready are both high
- i_rs1  in  XLEN  base register
- i_rs2  in  XLEN  store data
- i_imm  in  XLEN  sign-extended offset
- i_load  in  1  load op
- i_store  in  1  store op
- i_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved
- i_usign  in  1  zero-extend load data
- i_itag  in  ITAG_W  instruction tag
- cmd_valid  out  1  bus command valid
- cmd_ready  in  1  bus command ready
- cmd_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0
- cmd_read  out  1  1 for read, 0 for write
- cmd_wdata  out  XLEN  lane-aligned write data
- cmd_wmask  out  XLEN/8  byte enables; all 0 on reads
- cmd_itag  out  ITAG_W  tag of the current op
- rsp_valid  in  1  bus response valid
- rsp_ready  out  1  response ready
- rsp_rdata  in  XLEN  read data
- rsp_err  in  1  bus error
- o_valid  out  1  write-back valid
- o_ready  in  1  write-back ready
- o_wdat  out  XLEN  load result; 0 for stores
- o_itag  out  ITAG_W  tag of the completed op
- o_err  out  1  bus error or misaligned error

Behaviour:
- Reset:
  - Asynchronous on rst high; state goes to IDLE.
  - All operand, data and error registers clear to 0.
  - cmd_valid, rsp_ready and o_valid are 0.
  - i_ready is 1, since it is decoded from state IDLE.
- Handshakes:
  - i_ready = (state == IDLE).
  - In IDLE, the accept cycle latches rs1+imm (truncated to ADDR_W), rs2, size, usign, load/store and itag.
  - Outputs are driven from registers and state only; there is no combinational path from i_* to cmd_* or o_*.
  - Once cmd_valid is raised, it and all cmd_* fields hold stable until cmd_ready.
  - o_valid and o_* hold stable until o_ready.
- Address decode:
  - off = addr[1:0]; sz_mask = 0001 for byte, 0011 for halfword, 1111 for word.
  - Misaligned when: halfword with off = 3, word with off != 0, or size 11 (any offset).
  - Split only when misaligned, SPLIT_EN = 1 and size != 11.
  - Beat0 address = {addr[ADDR_W-1:2], 00}.
  - Beat1 address = beat0 + 4, wrapping modulo 2^ADDR_W.
- Stores:
  - wdata = rs2 rotated left by 8*off.
  - m8 = sz_mask << off (8 bits); beat0 mask = m8[3:0], beat1 mask = m8[7:4].
- Loads:
  - The 64-bit value {rdata1, rdata0} is shifted right by 8*off; unsplit loads use rdata1 = 0.
  - The low byte, halfword or word is taken by size, then zero-extended if usign, else sign-extended.
- Neither load nor store: the op is accepted and goes straight to WB with o_wdat = 0, o_err = 0.
- FSM states and transitions:
  - IDLE: on accept, go to CMD0. If misaligned and not splittable, go to WB with err = 1 instead.
  - CMD0: cmd_valid = 1; on cmd_ready go to RSP0.
  - RSP0: rsp_ready = 1; on rsp_valid capture rdata0 and err.
    - If rsp_err, go to WB (beat1 is skipped).
    - Else if split, go to CMD1; otherwise go to WB.
  - CMD1: cmd_valid = 1; on cmd_ready go to RSP1.
  - RSP1: rsp_ready = 1; on rsp_valid capture rdata1, OR rsp_err into err, then go to WB.
  - WB: o_valid = 1; on o_ready go to IDLE.
- Latency with all ready signals held high and responses returned the cycle after the command:
  - Aligned op: accept at T, cmd at T+1, rsp at T+2, o_valid at T+3.
  - Split op: accept at T, cmd0 at T+1, rsp0 at T+2, cmd1 at T+3, rsp1 at T+4, o_valid at T+5.
- rsp_valid outside RSP0/RSP1 is ignored; rsp_ready is 0 there.
- On o_err, o_wdat is 0.
- Reset mid-operation returns to IDLE immediately. Any pending command or write-back is dropped without a handshake.
- Back-to-back ops: after the WB handshake at cycle N, i_ready is 1 at N+1.

Decomposition:
- Shared package (defines include) holds:
  - size codes SZ_B, SZ_H, SZ_W;
  - FSM state encodings IDLE, CMD0, RSP0, CMD1, RSP1, WB;
  - the XLEN/8 lane-count constant.
- One sub-module, lsu_agu_ldalign: purely combinational {rdata1, rdata0}, off, size and usign to o_wdat. It is reused later by the LSU.

Test Plan:
- Aligned word load: rs1 = 0x100, imm = 4, response 0xDEADBEEF -> one cmd at addr 0x104 with read = 1, o_wdat = 0xDEADBEEF, o_err = 0, o_valid at T+3.
- Byte store: rs1 = 0x203, imm = 0, rs2 = 0x000000A5 -> cmd addr 0x200, wmask 1000, wdata 0xA5xxxxxx, then write-back with o_wdat = 0.
- Split signed halfword load at addr 0x0007: rdata0 = 0x80112233, rdata1 = 0x55667788 -> cmds at 0x0004 then 0x0008, o_wdat = 0xFFFF8880.
- Split word store at 0xFFFE with ADDR_W = 16, rs2 = 0x11223344 -> beat0 addr 0xFFFC mask 1100, beat1 addr 0x0000 (wrap) mask 0011, wdata 0x33441122 on both beats.
- Split load with beat0 rsp_err = 1 -> no second cmd, o_err = 1, o_wdat = 0. With SPLIT_EN = 0, misaligned word at 0x0001 -> no cmd, o_err = 1 at T+1.
- Stalls and reset: hold cmd_ready = 0 for 3 cycles and o_ready = 0 for 2 cycles -> cmd_* and o_* stable throughout. Assert rst in RSP0 -> next edge shows IDLE, i_ready = 1, cmd_valid = 0, o_valid = 0.
